// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
// Sole driver of the framebuffer write port. Two requesters (0 = host,
// 1 = rasterizer) share the port through valid/ready handshakes with
// round-robin arbitration. A clear sequencer fills the frame with one
// palette index, one pixel per cycle, in raster order. All write-port
// outputs are registered; at most one write retires per clock.
//
// Optional build macro: FB_ARB_BOUNDS_CHECK_EN
//   defined   : out-of-range requests are accepted but dropped, oob_o pulses
//   undefined : coordinates pass through unchecked, oob_o tied to 0
module framebuffer_write_arbiter #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int PW = $clog2(PALETTE_LENGTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [1:0]    req_valid_i,
  output logic [1:0]    req_ready_o,
  input  logic [XW-1:0] req0_x_i,
  input  logic [YW-1:0] req0_y_i,
  input  logic [PW-1:0] req0_index_i,
  input  logic [XW-1:0] req1_x_i,
  input  logic [YW-1:0] req1_y_i,
  input  logic [PW-1:0] req1_index_i,
  input  logic          clear_start_i,
  input  logic [PW-1:0] clear_index_i,
  output logic          clear_busy_o,
  output logic          clear_done_o,
  output logic          we_o,
  output logic [XW-1:0] wr_pxl_x_o,
  output logic [YW-1:0] wr_pxl_y_o,
  output logic [PW-1:0] wr_palette_index_o,
  output logic          oob_o
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [XW-1:0] X_MAX = XW'(RESOLUTION_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(RESOLUTION_Y - 1);

  logic [0:0]    state;
  logic          last_grant;    // requester that won the most recent transfer
  logic          clear_last;    // final pixel of the sweep has been emitted
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [PW-1:0] clr_index;

  logic [1:0]    xfer;
  logic          sel;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [PW-1:0] sel_index;

  logic [XW-1:0] cur_x, nxt_x;
  logic [YW-1:0] cur_y, nxt_y;
  logic [PW-1:0] cur_index;
  logic          x_last, y_last;

  // Grant: clear beats requesters, lone valid wins, contention goes to the
  // requester that did not win last time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_ready_o = 2'b00;
    if (reset_ni && state == ST_ARB && !clear_start_i) begin
      unique case (req_valid_i)
        2'b01:   req_ready_o = 2'b01;
        2'b10:   req_ready_o = 2'b10;
        2'b11:   req_ready_o = last_grant ? 2'b01 : 2'b10;
        default: req_ready_o = 2'b00;
      endcase
    end
  end

  // Select the granted request's fields.
  always_comb begin
    xfer      = req_valid_i & req_ready_o;
    sel       = xfer[1];
    sel_x     = sel ? req1_x_i     : req0_x_i;
    sel_y     = sel ? req1_y_i     : req0_y_i;
    sel_index = sel ? req1_index_i : req0_index_i;
  end

  // Sweep position: the pixel emitted this edge (origin when starting from
  // ARB) and the raster-order successor.
  always_comb begin
    cur_x     = (state == ST_ARB) ? '0 : clr_x;
    cur_y     = (state == ST_ARB) ? '0 : clr_y;
    cur_index = (state == ST_ARB) ? clear_index_i : clr_index;
    x_last    = (cur_x == X_MAX);
    y_last    = (cur_y == Y_MAX);
    nxt_x     = x_last ? '0 : cur_x + 1'b1;
    nxt_y     = x_last ? cur_y + 1'b1 : cur_y;
  end

`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam logic [XW:0] X_LIM = (XW+1)'(RESOLUTION_X);
  localparam logic [YW:0] Y_LIM = (YW+1)'(RESOLUTION_Y);
  logic sel_oob;
  assign sel_oob = ({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM);
`endif

  // Arbitration / clear FSM and registered write port.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state              <= ST_ARB;
      last_grant         <= 1'b1;
      clear_last         <= 1'b0;
      clr_x              <= '0;
      clr_y              <= '0;
      clr_index          <= '0;
      clear_busy_o       <= 1'b0;
      clear_done_o       <= 1'b0;
      we_o               <= 1'b0;
      wr_pxl_x_o         <= '0;
      wr_pxl_y_o         <= '0;
      wr_palette_index_o <= '0;
`ifdef FB_ARB_BOUNDS_CHECK_EN
      oob_o              <= 1'b0;
`endif
    end else begin
      we_o         <= 1'b0;
      clear_done_o <= 1'b0;
`ifdef FB_ARB_BOUNDS_CHECK_EN
      oob_o        <= 1'b0;
`endif
      if (state == ST_ARB) begin
        if (clear_start_i) begin
          // First pixel goes out immediately; counters hold the next one.
          clr_index          <= clear_index_i;
          we_o               <= 1'b1;
          wr_pxl_x_o         <= cur_x;
          wr_pxl_y_o         <= cur_y;
          wr_palette_index_o <= cur_index;
          clr_x              <= nxt_x;
          clr_y              <= nxt_y;
          clear_last         <= x_last && y_last;
          clear_busy_o       <= 1'b1;
          state              <= ST_CLEAR;
        end else if (|xfer) begin
          last_grant         <= sel;
          wr_pxl_x_o         <= sel_x;
          wr_pxl_y_o         <= sel_y;
          wr_palette_index_o <= sel_index;
`ifdef FB_ARB_BOUNDS_CHECK_EN
          we_o               <= !sel_oob;
          oob_o              <= sel_oob;
`else
          we_o               <= 1'b1;
`endif
        end
      end else begin
        if (clear_last) begin
          clear_last   <= 1'b0;
          clear_busy_o <= 1'b0;
          clear_done_o <= 1'b1;
          state        <= ST_ARB;
        end else begin
          we_o               <= 1'b1;
          wr_pxl_x_o         <= cur_x;
          wr_pxl_y_o         <= cur_y;
          wr_palette_index_o <= cur_index;
          clr_x              <= nxt_x;
          clr_y              <= nxt_y;
          clear_last         <= x_last && y_last;
        end
      end
    end
  end

`ifndef FB_ARB_BOUNDS_CHECK_EN
  assign oob_o = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Directed bench for framebuffer_write_arbiter at a 4x3 frame, 16 colours.
module tb_framebuffer_write_arbiter;

  localparam int RX = 4;
  localparam int RY = 3;
  localparam int PL = 16;
  localparam int XW = $clog2(RX);
  localparam int YW = $clog2(RY);
  localparam int PW = $clog2(PL);

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [1:0]    req_valid_i;
  logic [1:0]    req_ready_o;
  logic [XW-1:0] req0_x_i, req1_x_i;
  logic [YW-1:0] req0_y_i, req1_y_i;
  logic [PW-1:0] req0_index_i, req1_index_i;
  logic          clear_start_i;
  logic [PW-1:0] clear_index_i;
  logic          clear_busy_o, clear_done_o, we_o, oob_o;
  logic [XW-1:0] wr_pxl_x_o;
  logic [YW-1:0] wr_pxl_y_o;
  logic [PW-1:0] wr_palette_index_o;

  int total = 0;
  int bad   = 0;

  framebuffer_write_arbiter #(
    .RESOLUTION_X  (RX),
    .RESOLUTION_Y  (RY),
    .PALETTE_LENGTH(PL)
  ) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req0_x_i          (req0_x_i),
    .req0_y_i          (req0_y_i),
    .req0_index_i      (req0_index_i),
    .req1_x_i          (req1_x_i),
    .req1_y_i          (req1_y_i),
    .req1_index_i      (req1_index_i),
    .clear_start_i     (clear_start_i),
    .clear_index_i     (clear_index_i),
    .clear_busy_o      (clear_busy_o),
    .clear_done_o      (clear_done_o),
    .we_o              (we_o),
    .wr_pxl_x_o        (wr_pxl_x_o),
    .wr_pxl_y_o        (wr_pxl_y_o),
    .wr_palette_index_o(wr_palette_index_o),
    .oob_o             (oob_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_ni      = 1'b0;
    req_valid_i   = 2'b11;
    req0_x_i      = 2'd1; req0_y_i = 2'd2; req0_index_i = 4'd5;
    req1_x_i      = 2'd3; req1_y_i = 2'd0; req1_index_i = 4'd9;
    clear_start_i = 1'b0;
    clear_index_i = 4'd0;

    // Reset held with both requesters valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_we",    32'(we_o),        32'd0);
    end
    check("rst_busy", 32'(clear_busy_o), 32'd0);
    check("rst_done", 32'(clear_done_o), 32'd0);
    check("rst_oob",  32'(oob_o),        32'd0);
    check("rst_x",    32'(wr_pxl_x_o),   32'd0);
    check("rst_idx",  32'(wr_palette_index_o), 32'd0);

    // Contention: grants alternate 0,1,0,1 starting with requester 0.
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready", 32'(req_ready_o), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("cont_we",  32'(we_o),               32'd1);
      check("cont_idx", 32'(wr_palette_index_o), (i % 2 == 0) ? 32'd5 : 32'd9);
      check("cont_x",   32'(wr_pxl_x_o),         (i % 2 == 0) ? 32'd1 : 32'd3);
      check("cont_y",   32'(wr_pxl_y_o),         (i % 2 == 0) ? 32'd2 : 32'd0);
    end
    req_valid_i = 2'b00;
    #1;
    check("idle_ready", 32'(req_ready_o), 32'd0);
    tick();
    check("idle_we", 32'(we_o), 32'd0);

    // Clear colliding with a requester-0 valid; restart attempt at pixel 5.
    clear_start_i = 1'b1;
    clear_index_i = 4'd7;
    req_valid_i   = 2'b01;
    #1;
    check("coll_ready", 32'(req_ready_o), 32'd0);
    tick();
    for (int p = 0; p < RX * RY; p++) begin
      check("clr_we",   32'(we_o),               32'd1);
      check("clr_x",    32'(wr_pxl_x_o),         32'(p % RX));
      check("clr_y",    32'(wr_pxl_y_o),         32'(p / RX));
      check("clr_idx",  32'(wr_palette_index_o), 32'd7);
      check("clr_busy", 32'(clear_busy_o),       32'd1);
      check("clr_done", 32'(clear_done_o),       32'd0);
      clear_start_i = (p == 5);
      clear_index_i = (p == 5) ? 4'd3 : 4'd7;
      #1;
      check("clr_ready", 32'(req_ready_o), 32'd0);
      tick();
    end
    clear_start_i = 1'b0;
    check("done_pulse", 32'(clear_done_o), 32'd1);
    check("done_busy",  32'(clear_busy_o), 32'd0);
    check("done_we",    32'(we_o),         32'd0);
    check("done_ready", 32'(req_ready_o),  32'd1);
    tick();
    check("post_done",   32'(clear_done_o),       32'd0);
    check("post_we",     32'(we_o),               32'd1);
    check("post_idx",    32'(wr_palette_index_o), 32'd5);
    req_valid_i = 2'b00;
    tick();
    check("post_idle_we", 32'(we_o), 32'd0);

    // Reset in the middle of a sweep.
    clear_start_i = 1'b1;
    clear_index_i = 4'd2;
    tick();
    clear_start_i = 1'b0;
    for (int p = 0; p < 6; p++) tick();
    check("mid_px6_x", 32'(wr_pxl_x_o), 32'd2);
    check("mid_px6_y", 32'(wr_pxl_y_o), 32'd1);
    reset_ni = 1'b0;
    tick();
    check("mid_rst_we",   32'(we_o),         32'd0);
    check("mid_rst_busy", 32'(clear_busy_o), 32'd0);
    reset_ni = 1'b1;
    tick();
    check("mid_no_done", 32'(clear_done_o), 32'd0);
    check("mid_no_we",   32'(we_o),         32'd0);
    req_valid_i = 2'b11;
    #1;
    check("mid_arb_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 2'b10;
    #1;
    check("mid_lone1_ready", 32'(req_ready_o), 32'd2);
    req_valid_i = 2'b00;
    tick();

    // Out-of-range y (3 >= 3) from requester 0.
    req_valid_i  = 2'b01;
    req0_x_i     = 2'd1;
    req0_y_i     = 2'd3;
    req0_index_i = 4'd3;
    #1;
    check("oob_ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 2'b00;
`ifdef FB_ARB_BOUNDS_CHECK_EN
    check("oob_we",    32'(we_o),  32'd0);
    check("oob_pulse", 32'(oob_o), 32'd1);
    tick();
    check("oob_clear", 32'(oob_o), 32'd0);
`else
    check("pass_we",  32'(we_o),               32'd1);
    check("pass_y",   32'(wr_pxl_y_o),         32'd3);
    check("pass_idx", 32'(wr_palette_index_o), 32'd3);
    check("pass_oob", 32'(oob_o),              32'd0);
    tick();
`endif
    check("final_we", 32'(we_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
